mm2s_cmd_arbiter: RTL and testbench
===================================

Name: mm2s_cmd_arbiter

Overview:
Shares the single event DataMover MM2S command/status pair between up to four command requesters in the memclk domain, e.g. nack retransmit, normal event readout and a debug readback.
- Arbitrates 72-bit commands onto one command port and stamps a routing tag into each one.
- Tracks outstanding commands in a tag FIFO and routes each 8-bit status beat back to the requester that issued the command.
- Sits between the readout generators and the event DataMover; no data-stream involvement.

Parameters:
NREQ, 3, number of requesters (1..4)
MAX_OUTSTANDING, 4, max commands issued without status returned (1..8, tag FIFO depth)
PRIO0, "TRUE", requester 0 has strict priority over round-robin among the rest

Ports:
memclk  in  1  clock
aresetn  in  1  reset
s_cmd_tdata  in  72*NREQ  requester commands, DataMover format
s_cmd_tvalid  in  NREQ  command valid per requester
s_cmd_tready  out  NREQ  command accepted per requester
m_cmd_tdata  out  72  command to DataMover
m_cmd_tvalid  out  1  command valid
m_cmd_tready  in  1  DataMover command ready
s_sts_tdata  in  8  DataMover status
s_sts_tvalid  in  1  status valid
s_sts_tready  out  1  status ready
m_sts_tdata  out  8*NREQ  routed status per requester
m_sts_tvalid  out  NREQ  routed status valid
m_sts_tready  in  NREQ  requester status ready
outstanding_o  out  4  commands in flight
err_o  out  1  sticky: status error bit, tag mismatch or orphan status
err_clr_i  in  1  clears err_o

Behaviour:
- Reset (aresetn) is synchronous, active-low, clocked on memclk.
- Reset values: m_cmd_tvalid=0, s_cmd_tready=0, m_sts_tvalid=0, outstanding_o=0, err_o=0, round-robin pointer=0, tag sequence=0, FSM=IDLE, tag FIFO empty.
- FSM, 2 states:
  - IDLE: if outstanding_o < MAX_OUTSTANDING and any s_cmd_tvalid, register the grant and go to ISSUE.
  - Grant rule: if PRIO0=="TRUE" and s_cmd_tvalid[0], grant 0. Otherwise round-robin starting at last_grant+1, wrapping at NREQ and skipping 0 when PRIO0=="TRUE".
  - ISSUE: m_cmd_tvalid=1. m_cmd_tdata = s_cmd_tdata[grant] with bits [67:64] replaced by tag = {seq[1:0], grant[1:0]}; all other bits pass unchanged.
  - ISSUE, continued: s_cmd_tready[grant] = m_cmd_tready; all other s_cmd_tready=0.
  - On the m_cmd handshake: push tag, seq+1 (2-bit wrap), last_grant=grant, return to IDLE.
- Throughput: at most 1 command per 2 cycles. Latency from s_cmd_tvalid to m_cmd_tvalid is 1 cycle.
- Requesters must hold tvalid/tdata stable until accepted (AXI rule). The grant is not revoked while in ISSUE, even if a higher-priority request arrives.
- At outstanding == MAX_OUTSTANDING, no grant is made; the FSM stays in IDLE.
- Status routing is combinational with 0-cycle latency.
  - With the FIFO non-empty and head id h: m_sts_tvalid[h]=s_sts_tvalid, m_sts_tdata[h]=s_sts_tdata, s_sts_tready=m_sts_tready[h]. Handshake pops the FIFO.
  - Other requesters' m_sts_tvalid=0. m_sts_tdata is broadcast to all requesters.
- Status errors set err_o (routing still follows the FIFO head):
  - s_sts_tdata[3:0] != head tag.
  - Any of s_sts_tdata[6:4] (INTERR/DECERR/SLVERR) set.
- Orphan status (FIFO empty): s_sts_tready=1, beat dropped, err_o set.
- Simultaneous push and pop: outstanding unchanged, FIFO pointers both advance.
- err_clr_i and a new error in the same cycle: err_o stays 1.
- Reset mid-ISSUE: command dropped, m_cmd_tvalid low on the next cycle. Statuses still in flight then arrive as orphans; this is an accepted consequence, and all modules reset together.

Decomposition:
- Shared package mm2s_arb_pkg:
  - DataMover command field offsets: TAG_LSB=64, BTT width 23, ADDR_LSB=32.
  - Status bit positions: OKAY=7, SLVERR=6, DECERR=5, INTERR=4.
  - Tag typedef (seq[1:0], id[1:0]).
- One sub-module: mm2s_tag_fifo, a synchronous register FIFO, 4-bit wide, depth MAX_OUTSTANDING, with count output.

Test Plan:
- Single command from req1 (tdata tag bits 0) → m_cmd tag=4'b0001, outstanding 1. Status 8'h81 → routed to m_sts[1], outstanding 0, err_o=0.
- req0, req1, req2 all valid continuously, PRIO0="TRUE" → req0 served every grant. Deassert req0 → grants alternate 1,2,1,2.
- m_cmd_tready held high, no status returned, 6 commands queued → exactly 4 issued, outstanding_o=4. Return one status → a 5th command issues.
- Status tag 4'b0010 while head tag is 4'b0001 → routed to req1, err_o=1. err_clr_i pulse → err_o=0.
- Status 8'h40 (SLVERR) → routed, err_o=1. Status while FIFO empty → s_sts_tready=1, no m_sts_tvalid, err_o=1.
- aresetn low during ISSUE with m_cmd_tready=0 → next cycle m_cmd_tvalid=0, outstanding_o=0. After release, the pending request re-arbitrates with seq=0.

Source files
------------

// File: rtl/mm2s_arb_pkg.sv
// Shared definitions for the MM2S command arbiter: DataMover command/status
// field positions and the routing tag layout stamped into each command.
package mm2s_arb_pkg;

  localparam int unsigned CMD_W    = 72;
  localparam int unsigned STS_W    = 8;

  localparam int unsigned TAG_LSB  = 64;
  localparam int unsigned TAG_W    = 4;
  localparam int unsigned BTT_W    = 23;
  localparam int unsigned ADDR_LSB = 32;

  localparam int unsigned STS_OKAY   = 7;
  localparam int unsigned STS_SLVERR = 6;
  localparam int unsigned STS_DECERR = 5;
  localparam int unsigned STS_INTERR = 4;

  typedef struct packed {
    logic [1:0] seq;
    logic [1:0] id;
  } tag_t;

  typedef enum logic {
    ST_IDLE,
    ST_ISSUE
  } arb_state_e;

endpackage

// File: rtl/mm2s_tag_fifo.sv
// Register FIFO holding the tags of commands issued but not yet answered by
// a status beat; the head selects where the next status is routed.
module mm2s_tag_fifo
  import mm2s_arb_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       push_i,
  input  tag_t       din_i,
  input  logic       pop_i,
  output tag_t       head_o,
  output logic       empty_o,
  output logic [3:0] count_o
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  tag_t          mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [3:0]    count_q, count_d;
  logic          do_push, do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty_o = (count_q == '0);
  assign do_push = push_i && (32'(count_q) < DEPTH);
  assign do_pop  = pop_i && !empty_o;
  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
    if (do_push && !do_pop)      count_d = count_q + 4'd1;
    else if (do_pop && !do_push) count_d = count_q - 4'd1;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/mm2s_cmd_arbiter.sv
// Shares one DataMover MM2S command/status pair between NREQ requesters:
// arbitrates and tags commands, routes each status beat back by FIFO head tag.
module mm2s_cmd_arbiter
  import mm2s_arb_pkg::*;
#(
  parameter int unsigned NREQ            = 3,
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter              PRIO0           = "TRUE"
) (
  input  logic                  memclk,
  input  logic                  aresetn,
  input  logic [CMD_W*NREQ-1:0] s_cmd_tdata,
  input  logic [NREQ-1:0]       s_cmd_tvalid,
  output logic [NREQ-1:0]       s_cmd_tready,
  output logic [CMD_W-1:0]      m_cmd_tdata,
  output logic                  m_cmd_tvalid,
  input  logic                  m_cmd_tready,
  input  logic [STS_W-1:0]      s_sts_tdata,
  input  logic                  s_sts_tvalid,
  output logic                  s_sts_tready,
  output logic [STS_W*NREQ-1:0] m_sts_tdata,
  output logic [NREQ-1:0]       m_sts_tvalid,
  input  logic [NREQ-1:0]       m_sts_tready,
  output logic [3:0]            outstanding_o,
  output logic                  err_o,
  input  logic                  err_clr_i
);

  localparam bit PRIO0_EN = (PRIO0 == "TRUE");

  arb_state_e state_q, state_d;
  logic [1:0] grant_q, grant_d;
  logic [1:0] last_q, last_d;
  logic [1:0] seq_q, seq_d;
  logic       err_q, err_d;

  logic [1:0]       arb_id;
  logic             arb_hit;
  logic [CMD_W-1:0] sel_cmd;
  tag_t             cur_tag;
  tag_t             head;
  logic             fifo_empty;
  logic             cmd_hs, sts_hs, sts_pop, new_err;

  // Round-robin as two passes: requesters above last grant first, then wrap.
  always_comb begin
    arb_id  = '0;
    arb_hit = 1'b0;
    if (PRIO0_EN && s_cmd_tvalid[0]) begin
      arb_hit = 1'b1;
    end else begin
      for (int unsigned j = 0; j < NREQ; j++) begin
        if (!arb_hit && s_cmd_tvalid[j] && (j > 32'(last_q)) && !(PRIO0_EN && j == 0)) begin
          arb_hit = 1'b1;
          arb_id  = 2'(j);
        end
      end
      for (int unsigned j = 0; j < NREQ; j++) begin
        if (!arb_hit && s_cmd_tvalid[j] && (j <= 32'(last_q)) && !(PRIO0_EN && j == 0)) begin
          arb_hit = 1'b1;
          arb_id  = 2'(j);
        end
      end
    end
  end

  always_comb begin
    sel_cmd = '0;
    for (int unsigned j = 0; j < NREQ; j++) begin
      if (2'(j) == grant_q) sel_cmd = s_cmd_tdata[j*CMD_W +: CMD_W];
    end
  end

  assign cur_tag = '{seq: seq_q, id: grant_q};

  always_comb begin
    m_cmd_tdata                    = sel_cmd;
    m_cmd_tdata[TAG_LSB +: TAG_W]  = cur_tag;
    m_cmd_tvalid                   = (state_q == ST_ISSUE);
    for (int unsigned j = 0; j < NREQ; j++) begin
      s_cmd_tready[j] = (state_q == ST_ISSUE) && (2'(j) == grant_q) && m_cmd_tready;
    end
  end

  assign cmd_hs = (state_q == ST_ISSUE) && m_cmd_tready;

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    seq_d   = seq_q;
    unique case (state_q)
      ST_IDLE: begin
        if ((32'(outstanding_o) < MAX_OUTSTANDING) && arb_hit) begin
          grant_d = arb_id;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (m_cmd_tready) begin
          seq_d   = seq_q + 2'd1;
          last_d  = grant_q;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Orphan beats are accepted and dropped so the DataMover never stalls.
  always_comb begin
    s_sts_tready = fifo_empty;
    for (int unsigned j = 0; j < NREQ; j++) begin
      m_sts_tvalid[j] = !fifo_empty && (head.id == 2'(j)) && s_sts_tvalid;
      if (!fifo_empty && head.id == 2'(j)) s_sts_tready = m_sts_tready[j];
    end
  end

  assign m_sts_tdata = {NREQ{s_sts_tdata}};
  assign sts_hs      = s_sts_tvalid && s_sts_tready;
  assign sts_pop     = sts_hs && !fifo_empty;
  assign new_err     = sts_hs && (fifo_empty
                                  || (s_sts_tdata[TAG_W-1:0] != head)
                                  || (|s_sts_tdata[STS_SLVERR:STS_INTERR]));
  assign err_d       = (err_q && !err_clr_i) || new_err;
  assign err_o       = err_q;

  always_ff @(posedge memclk) begin
    if (!aresetn) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      last_q  <= '0;
      seq_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      seq_q   <= seq_d;
      err_q   <= err_d;
    end
  end

  mm2s_tag_fifo #(
    .DEPTH (MAX_OUTSTANDING)
  ) u_tag_fifo (
    .clk_i   (memclk),
    .rst_n_i (aresetn),
    .push_i  (cmd_hs),
    .din_i   (cur_tag),
    .pop_i   (sts_pop),
    .head_o  (head),
    .empty_o (fifo_empty),
    .count_o (outstanding_o)
  );

endmodule

// File: tb/tb_mm2s_cmd_arbiter.sv
// Directed-vector bench for mm2s_cmd_arbiter (NREQ=3, depth 4, PRIO0 on).
module tb_mm2s_cmd_arbiter;

  localparam int unsigned NREQ = 3;
  localparam int unsigned MAXO = 4;

  logic              memclk = 1'b0;
  logic              aresetn;
  logic [72*NREQ-1:0] s_cmd_tdata;
  logic [NREQ-1:0]   s_cmd_tvalid;
  logic [NREQ-1:0]   s_cmd_tready;
  logic [71:0]       m_cmd_tdata;
  logic              m_cmd_tvalid;
  logic              m_cmd_tready;
  logic [7:0]        s_sts_tdata;
  logic              s_sts_tvalid;
  logic              s_sts_tready;
  logic [8*NREQ-1:0] m_sts_tdata;
  logic [NREQ-1:0]   m_sts_tvalid;
  logic [NREQ-1:0]   m_sts_tready;
  logic [3:0]        outstanding_o;
  logic              err_o;
  logic              err_clr_i;

  mm2s_cmd_arbiter #(
    .NREQ            (NREQ),
    .MAX_OUTSTANDING (MAXO),
    .PRIO0           ("TRUE")
  ) dut (
    .memclk        (memclk),
    .aresetn       (aresetn),
    .s_cmd_tdata   (s_cmd_tdata),
    .s_cmd_tvalid  (s_cmd_tvalid),
    .s_cmd_tready  (s_cmd_tready),
    .m_cmd_tdata   (m_cmd_tdata),
    .m_cmd_tvalid  (m_cmd_tvalid),
    .m_cmd_tready  (m_cmd_tready),
    .s_sts_tdata   (s_sts_tdata),
    .s_sts_tvalid  (s_sts_tvalid),
    .s_sts_tready  (s_sts_tready),
    .m_sts_tdata   (m_sts_tdata),
    .m_sts_tvalid  (m_sts_tvalid),
    .m_sts_tready  (m_sts_tready),
    .outstanding_o (outstanding_o),
    .err_o         (err_o),
    .err_clr_i     (err_clr_i)
  );

  always #5 memclk = ~memclk;

  int unsigned n_vec  = 0;
  int unsigned n_miss = 0;
  logic [3:0]  issued[$];
  logic [3:0]  pend[$];
  bit          keep_req = 1'b0;
  bit          auto_sts = 1'b0;

  localparam logic [71:0] DATA0 = {4'h3, 4'hF, 32'h0123_4567, 32'h89AB_CDEF};
  localparam logic [71:0] DATA1 = {4'hA, 4'h0, 32'h1234_5678, 32'h0080_0100};
  localparam logic [71:0] DATA2 = {4'h5, 4'hF, 32'hDEAD_BEEF, 32'h4000_0040};

  task automatic chk(input string tag, input logic [71:0] got, input logic [71:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One clock: record handshakes seen before the edge, then update requester
  // and status-responder stimulus just after it.
  task automatic tick();
    logic [NREQ-1:0] acc;
    logic            cmd_hs, sts_hs;
    logic [3:0]      ctag;
    #1;
    acc    = s_cmd_tvalid & s_cmd_tready;
    cmd_hs = m_cmd_tvalid && m_cmd_tready;
    ctag   = m_cmd_tdata[67:64];
    sts_hs = s_sts_tvalid && s_sts_tready;
    @(posedge memclk);
    #1;
    if (cmd_hs && aresetn) issued.push_back(ctag);
    if (!keep_req) s_cmd_tvalid &= ~acc;
    if (sts_hs && pend.size() > 0) void'(pend.pop_front());
    if (cmd_hs && aresetn) pend.push_back(ctag);
    if (auto_sts) begin
      s_sts_tvalid = (pend.size() > 0);
      s_sts_tdata  = (pend.size() > 0) ? {4'h8, pend[0]} : 8'h00;
    end
  endtask

  task automatic do_reset();
    aresetn = 1'b0;
    tick();
    aresetn = 1'b1;
    pend.delete();
  endtask

  initial begin
    logic [3:0] exp_p [8];
    logic [3:0] exp_f [4];
    int unsigned bound;

    aresetn      = 1'b0;
    s_cmd_tdata  = {DATA2, DATA1, DATA0};
    s_cmd_tvalid = '0;
    m_cmd_tready = 1'b1;
    s_sts_tdata  = '0;
    s_sts_tvalid = 1'b0;
    m_sts_tready = '1;
    err_clr_i    = 1'b0;
    repeat (3) tick();
    aresetn = 1'b1;
    pend.delete();

    chk("rst_m_cmd_tvalid", 72'(m_cmd_tvalid), 72'd0);
    chk("rst_s_cmd_tready", 72'(s_cmd_tready), 72'd0);
    chk("rst_m_sts_tvalid", 72'(m_sts_tvalid), 72'd0);
    chk("rst_outstanding",  72'(outstanding_o), 72'd0);
    chk("rst_err",          72'(err_o), 72'd0);

    // Single command from req1, then its OKAY status.
    s_cmd_tvalid = 3'b010;
    #1;
    chk("t1_no_same_cycle_valid", 72'(m_cmd_tvalid), 72'd0);
    tick();
    chk("t1_m_cmd_tvalid", 72'(m_cmd_tvalid), 72'd1);
    chk("t1_m_cmd_tdata",  m_cmd_tdata, {4'hA, 4'b0001, 32'h1234_5678, 32'h0080_0100});
    chk("t1_s_cmd_tready", 72'(s_cmd_tready), 72'(3'b010));
    tick();
    chk("t1_outstanding_1", 72'(outstanding_o), 72'd1);
    chk("t1_idle_after_hs", 72'(m_cmd_tvalid), 72'd0);
    s_sts_tdata  = 8'h81;
    s_sts_tvalid = 1'b1;
    #1;
    chk("t1_sts_route",  72'(m_sts_tvalid), 72'(3'b010));
    chk("t1_sts_data",   72'(m_sts_tdata), 72'({3{8'h81}}));
    chk("t1_sts_tready", 72'(s_sts_tready), 72'd1);
    tick();
    s_sts_tvalid = 1'b0;
    chk("t1_outstanding_0", 72'(outstanding_o), 72'd0);
    chk("t1_err", 72'(err_o), 72'd0);

    // Priority: req0 wins while valid; then 1,2 round-robin. seq starts at 1.
    issued.delete();
    keep_req     = 1'b1;
    auto_sts     = 1'b1;
    s_cmd_tvalid = 3'b111;
    bound = 0;
    while (issued.size() < 4 && bound < 40) begin tick(); bound++; end
    s_cmd_tvalid[0] = 1'b0;
    while (issued.size() < 8 && bound < 80) begin tick(); bound++; end
    s_cmd_tvalid = '0;
    keep_req     = 1'b0;
    chk("t2_issue_count", 72'(issued.size()), 72'd8);
    exp_p = '{4'b0100, 4'b1000, 4'b1100, 4'b0000, 4'b0101, 4'b1010, 4'b1101, 4'b0010};
    for (int i = 0; i < 8; i++) chk($sformatf("t2_tag%0d", i), 72'(issued[i]), 72'(exp_p[i]));
    bound = 0;
    while (pend.size() > 0 && bound < 20) begin tick(); bound++; end
    auto_sts     = 1'b0;
    s_sts_tvalid = 1'b0;
    chk("t2_drained", 72'(outstanding_o), 72'd0);
    chk("t2_err", 72'(err_o), 72'd0);

    // Outstanding limit: no status returned, requesters 1 and 2 keep asking.
    issued.delete();
    keep_req     = 1'b1;
    s_cmd_tvalid = 3'b110;
    repeat (20) tick();
    chk("t3_issue_count", 72'(issued.size()), 72'd4);
    chk("t3_outstanding", 72'(outstanding_o), 72'd4);
    chk("t3_no_cmd_at_full", 72'(m_cmd_tvalid), 72'd0);
    exp_f = '{4'b0101, 4'b1010, 4'b1101, 4'b0010};
    for (int i = 0; i < 4; i++) chk($sformatf("t3_tag%0d", i), 72'(issued[i]), 72'(exp_f[i]));
    s_sts_tdata  = 8'h85;
    s_sts_tvalid = 1'b1;
    #1;
    chk("t3_sts_route", 72'(m_sts_tvalid), 72'(3'b010));
    tick();
    s_sts_tvalid = 1'b0;
    bound = 0;
    while (issued.size() < 5 && bound < 6) begin tick(); bound++; end
    s_cmd_tvalid = '0;
    keep_req     = 1'b0;
    chk("t3_fifth_issued", 72'(issued.size()), 72'd5);
    chk("t3_fifth_tag", 72'(issued[4]), 72'(4'b0101));
    chk("t3_outstanding_again", 72'(outstanding_o), 72'd4);

    // Tag mismatch: head tag 0001, status carries 0010.
    do_reset();
    chk("t4_rst_outstanding", 72'(outstanding_o), 72'd0);
    s_cmd_tvalid = 3'b010;
    tick();
    tick();
    chk("t4_outstanding", 72'(outstanding_o), 72'd1);
    s_sts_tdata  = 8'h82;
    s_sts_tvalid = 1'b1;
    #1;
    chk("t4_sts_route", 72'(m_sts_tvalid), 72'(3'b010));
    tick();
    s_sts_tvalid = 1'b0;
    chk("t4_err_set", 72'(err_o), 72'd1);
    chk("t4_outstanding_0", 72'(outstanding_o), 72'd0);
    err_clr_i = 1'b1;
    tick();
    err_clr_i = 1'b0;
    chk("t4_err_clr", 72'(err_o), 72'd0);

    // SLVERR on a correctly tagged status, with backpressure first.
    s_cmd_tvalid = 3'b100;
    tick();
    chk("t5_m_cmd_tdata", m_cmd_tdata, {4'h5, 4'b0110, 32'hDEAD_BEEF, 32'h4000_0040});
    tick();
    chk("t5_outstanding", 72'(outstanding_o), 72'd1);
    s_sts_tdata  = 8'h46;
    s_sts_tvalid = 1'b1;
    m_sts_tready = 3'b011;
    #1;
    chk("t5_backpressure", 72'(s_sts_tready), 72'd0);
    m_sts_tready = 3'b111;
    #1;
    chk("t5_sts_route", 72'(m_sts_tvalid), 72'(3'b100));
    chk("t5_sts_data",  72'(m_sts_tdata), 72'({3{8'h46}}));
    tick();
    s_sts_tvalid = 1'b0;
    chk("t5_err_slverr", 72'(err_o), 72'd1);
    chk("t5_outstanding_0", 72'(outstanding_o), 72'd0);

    // Orphan status coinciding with err_clr_i: error wins.
    s_sts_tdata  = 8'h80;
    s_sts_tvalid = 1'b1;
    err_clr_i    = 1'b1;
    #1;
    chk("t5_orphan_tready", 72'(s_sts_tready), 72'd1);
    chk("t5_orphan_no_route", 72'(m_sts_tvalid), 72'd0);
    tick();
    s_sts_tvalid = 1'b0;
    err_clr_i    = 1'b0;
    chk("t5_orphan_err", 72'(err_o), 72'd1);
    err_clr_i = 1'b1;
    tick();
    err_clr_i = 1'b0;
    chk("t5_err_clr", 72'(err_o), 72'd0);

    // Reset while a command is stalled in ISSUE.
    m_cmd_tready = 1'b0;
    s_cmd_tvalid = 3'b100;
    tick();
    chk("t6_issue_valid", 72'(m_cmd_tvalid), 72'd1);
    chk("t6_stalled_tready", 72'(s_cmd_tready), 72'd0);
    do_reset();
    chk("t6_rst_m_cmd_tvalid", 72'(m_cmd_tvalid), 72'd0);
    chk("t6_rst_outstanding", 72'(outstanding_o), 72'd0);
    tick();
    chk("t6_reissue_tag", 72'(m_cmd_tdata[67:64]), 72'(4'b0010));
    m_cmd_tready = 1'b1;
    #1;
    chk("t6_s_cmd_tready", 72'(s_cmd_tready), 72'(3'b100));
    tick();
    chk("t6_outstanding", 72'(outstanding_o), 72'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
